// File: rtl/fir_sched.sv
// fir_sched: round-robin block scheduler feeding a shared FIR.
// A granted channel streams BLOCK_LEN samples, then the FIR delay line is
// flushed with FLUSH_LEN zero cycles so blocks from different channels never
// mix inside the filter. Results return tagged with their channel through a
// credit-protected output FIFO.
module fir_sched #(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int BLOCK_LEN   = 16,
    parameter int FLUSH_LEN   = 40,
    parameter int FIR_LATENCY = 5,
    parameter int OUT_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_enable,
    input  logic [NUM_CH-1:0]            i_req_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_CH-1:0]            o_req_ready,
    output logic [DATA_WIDTH-1:0]        o_fir_data_in,
    output logic                         o_fir_valid_in,
    input  logic [DATA_WIDTH-1:0]        i_fir_data_out,
    input  logic                         i_fir_valid_out,
    output logic                         o_out_valid,
    output logic [DATA_WIDTH-1:0]        o_out_data,
    output logic [$clog2(NUM_CH)-1:0]    o_out_ch,
    input  logic                         i_out_ready,
    output logic                         o_idle
);
    localparam int CW = $clog2(NUM_CH);
    localparam int BW = $clog2(BLOCK_LEN + 1);
    localparam int FW = $clog2(FLUSH_LEN + 1);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int NW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_last_grant;
    logic [CW-1:0]         r_grant;
    logic [BW-1:0]         r_cnt;
    logic [FW-1:0]         r_flush;
    logic [NW-1:0]         r_inflight;
    logic [NW-1:0]         r_count;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_tag [FIR_LATENCY+1];
    logic [DATA_WIDTH-1:0] r_mem_d [OUT_DEPTH];
    logic [CW-1:0]         r_mem_c [OUT_DEPTH];

    logic                  w_pick_ok;
    logic [CW-1:0]         w_pick;
    logic [CW-1:0]         w_idx;
    logic                  w_credit;
    logic                  w_hs;
    logic [DATA_WIDTH-1:0] w_sample;
    logic                  w_push;
    logic                  w_pop;

    // Round-robin pick: scan from furthest to nearest after last_grant so the
    // nearest valid channel is the one left standing.
    always_comb begin
        w_pick_ok = 1'b0;
        w_pick    = '0;
        w_idx     = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            w_idx = r_last_grant + CW'(i);
            if (i_req_valid[w_idx]) begin
                w_pick_ok = 1'b1;
                w_pick    = w_idx;
            end
        end
    end

    // Credit: every accepted sample owns a FIFO slot until it is popped.
    assign w_credit = ({1'b0, r_inflight} + {1'b0, r_count}) < (NW+1)'(OUT_DEPTH);

    // Only the granted channel may be ready, and only while streaming.
    always_comb begin
        o_req_ready = '0;
        if (r_state == STREAM && w_credit)
            o_req_ready[r_grant] = 1'b1;
    end

    assign w_hs     = |(i_req_valid & o_req_ready);
    assign w_sample = i_req_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
    // A result with nothing outstanding is stale (e.g. issued before reset).
    assign w_push   = i_fir_valid_out && (r_inflight != '0);
    assign w_pop    = (r_count != '0) && i_out_ready;

    // Block FSM: grant, count BLOCK_LEN handshakes, then hold off FLUSH_LEN cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= CW'(NUM_CH - 1);
            r_grant      <= '0;
            r_cnt        <= '0;
            r_flush      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_enable && w_pick_ok) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_cnt        <= '0;
                        r_state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_hs) begin
                        if (r_cnt == BW'(BLOCK_LEN - 1)) begin
                            r_flush <= '0;
                            r_state <= FLUSH;
                        end else begin
                            r_cnt <= r_cnt + BW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (r_flush == FW'(FLUSH_LEN - 1))
                        r_state <= IDLE;
                    else
                        r_flush <= r_flush + FW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // FIR feed: the filter shifts every cycle, so idle cycles carry zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_fir_valid_in <= 1'b0;
            o_fir_data_in  <= '0;
        end else begin
            o_fir_valid_in <= w_hs;
            o_fir_data_in  <= w_hs ? w_sample : '0;
        end
    end

    // Channel tags ride alongside the FIR pipeline; the tail lines up with fir_valid_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= FIR_LATENCY; i++)
                r_tag[i] <= '0;
        end else begin
            r_tag[0] <= w_hs ? r_grant : '0;
            for (int i = 1; i <= FIR_LATENCY; i++)
                r_tag[i] <= r_tag[i-1];
        end
    end

    // Samples issued to the FIR whose results have not yet landed in the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
        end else begin
            case ({w_hs, w_push})
                2'b10:   r_inflight <= r_inflight + NW'(1);
                2'b01:   r_inflight <= r_inflight - NW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Output FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= (r_wptr == PW'(OUT_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= (r_rptr == PW'(OUT_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + NW'(1);
                2'b01:   r_count <= r_count - NW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_d[r_wptr] <= i_fir_data_out;
            r_mem_c[r_wptr] <= r_tag[FIR_LATENCY];
        end
    end

    assign o_out_valid = (r_count != '0);
    assign o_out_data  = o_out_valid ? r_mem_d[r_rptr] : '0;
    assign o_out_ch    = o_out_valid ? r_mem_c[r_rptr] : '0;
    assign o_idle      = (r_state == IDLE) && (r_inflight == '0) && (r_count == '0);

endmodule

// File: doc/fir_sched.md
FIR_SCHED -- requirements
Module: fir_sched

Interface
REQ-001 Parameter NUM_CH, 4, number of requesting sample channels (power of 2, >=2).
REQ-002 Parameter DATA_WIDTH, 8, sample width; equals FIR datapath width.
REQ-003 Parameter BLOCK_LEN, 16, samples per granted block (>=1).
REQ-004 Parameter FLUSH_LEN, 40, idle cycles between blocks; equals FIR tap count.
REQ-005 Parameter FIR_LATENCY, 5, cycles from fir_valid_in to fir_valid_out.
REQ-006 Parameter OUT_DEPTH, 8, output FIFO entries.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 enable  in  1  permits new block grants.
REQ-010 req_valid  in  NUM_CH  per-channel sample valid.
REQ-011 req_data  in  NUM_CH*DATA_WIDTH  per-channel sample; channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-012 req_ready  out  NUM_CH  per-channel accept; one-hot or zero.
REQ-013 fir_data_in  out  DATA_WIDTH  registered sample to FIR.
REQ-014 fir_valid_in  out  1  registered sample valid to FIR.
REQ-015 fir_data_out  in  DATA_WIDTH  FIR result.
REQ-016 fir_valid_out  in  1  FIR result valid.
REQ-017 out_valid  out  1  output FIFO not empty.
REQ-018 out_data  out  DATA_WIDTH  FIFO head result.
REQ-019 out_ch  out  log2(NUM_CH)  FIFO head channel tag.
REQ-020 out_ready  in  1  consumer accept.
REQ-021 idle  out  1  state IDLE, nothing in flight, FIFO empty.

Function
REQ-022 FSM states IDLE, STREAM, FLUSH; handshake on channel c = req_valid[c] & req_ready[c].
REQ-023 IDLE: if enable and any req_valid, grant the first valid channel after last_grant in round-robin order (wrap NUM_CH-1 -> 0), record last_grant, go STREAM next cycle, clear sample count.
REQ-024 STREAM: req_ready[grant] = (inflight + fifo_count < OUT_DEPTH); all other req_ready bits 0.
REQ-025 Each handshake: fir_data_in <= sample, fir_valid_in <= 1 next cycle; non-handshake cycles: fir_data_in <= 0, fir_valid_in <= 0 (FIR delay line always shifts; gaps insert zeros).
REQ-026 Handshake with sample count = BLOCK_LEN-1 -> FLUSH; enable is ignored mid-block.
REQ-027 FLUSH: exactly FLUSH_LEN cycles, req_ready = 0, fir_valid_in = 0, then IDLE.
REQ-028 Channel tag shift register, depth FIR_LATENCY+1, tracks granted channel of each issued sample; tag at tail pushed with fir_data_out when fir_valid_out = 1.
REQ-029 inflight: +1 per handshake, -1 per fir_valid_out, both same cycle = unchanged; never exceeds OUT_DEPTH.
REQ-030 Output FIFO: push on fir_valid_out, pop on out_valid & out_ready; simultaneous push/pop at full or empty legal, count unchanged; write/read pointers wrap modulo OUT_DEPTH.
REQ-031 Credit rule guarantees push never occurs when full; fir_valid_out with no inflight is ignored.
REQ-032 out_data/out_ch are FIFO head, stable while out_valid & !out_ready.
REQ-033 Latency: handshake at cycle t -> fir_valid_in at t+1 -> FIFO entry, out_valid at t+FIR_LATENCY+2 when previously empty.

Reset
REQ-034 Reset forces IDLE, last_grant = NUM_CH-1, counters, inflight, pointers, tag register 0.
REQ-035 Reset values: req_ready 0, fir_data_in 0, fir_valid_in 0, out_valid 0, out_data 0, out_ch 0, idle 1.
REQ-036 Reset mid-operation discards in-flight samples and FIFO contents; no output after reset deassertion until a new handshake.

Verification
REQ-037 enable=1, only ch2 valid, BLOCK_LEN=16, out_ready=1 -> 16 consecutive fir_valid_in, 40 flush cycles, 16 outputs with out_ch=2, first at handshake+7.
REQ-038 All channels valid continuously -> grant order 0,1,2,3,0; each block 16 samples, 40-cycle gap between blocks.
REQ-039 out_ready=0, ch0 streaming -> exactly 8 handshakes then req_ready=0; FIFO full; one out_ready pulse -> one further handshake.
REQ-040 req_valid toggling every other cycle mid-block -> fir_data_in=0, fir_valid_in=0 in gap cycles; block still ends after 16 handshakes.
REQ-041 enable dropped at block sample 5 -> block completes, FLUSH runs, IDLE with no new grant; idle=1 after FIFO drains.
REQ-042 reset asserted with 3 samples in flight and 4 in FIFO -> all outputs at reset values, idle=1, no stale fir_valid_out pushed.
